// File: rtl/bram_2p_byte_en.sv
// True dual-port byte-enable block RAM, one clock.
// Port A wins column conflicts; read data optionally re-registered.
module bram_2p_byte_en #(
  parameter int    NB_COL        = 4,
  parameter int    COL_WIDTH     = 8,
  parameter int    RAM_ADDR_BITS = 10,
  parameter string READ_MODE     = "WRITE_FIRST",
  parameter int    OUT_REG       = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          a_en_i,
  input  logic [NB_COL-1:0]             a_we_i,
  input  logic [RAM_ADDR_BITS-1:0]      a_addr_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   a_data_i,
  output logic [NB_COL*COL_WIDTH-1:0]   a_data_o,
  output logic                          a_valid_o,
  input  logic                          b_en_i,
  input  logic [NB_COL-1:0]             b_we_i,
  input  logic [RAM_ADDR_BITS-1:0]      b_addr_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   b_data_i,
  output logic [NB_COL*COL_WIDTH-1:0]   b_data_o,
  output logic                          b_valid_o
);

  localparam int W     = NB_COL * COL_WIDTH;
  localparam int DEPTH = 2 ** RAM_ADDR_BITS;
  localparam bit RD_FIRST  = (READ_MODE == "READ_FIRST");
  localparam bit NO_CHANGE = (READ_MODE == "NO_CHANGE");

  logic [W-1:0] mem [DEPTH];

  logic [1:0]                          en;
  logic [1:0][NB_COL-1:0]              we;
  logic [1:0][RAM_ADDR_BITS-1:0]       addr;
  logic [1:0][W-1:0]                   din;
  logic [1:0][W-1:0]                   dout;
  logic [1:0]                          vout;

  assign en   = {b_en_i, a_en_i};
  assign we   = {b_we_i, a_we_i};
  assign addr = {b_addr_i, a_addr_i};
  assign din  = {b_data_i, a_data_i};

  assign a_data_o  = dout[0];
  assign a_valid_o = vout[0];
  assign b_data_o  = dout[1];
  assign b_valid_o = vout[1];

  // B is applied first so A's later assignment wins shared columns
  always_ff @(posedge clk_i) begin
    for (int p = 1; p >= 0; p--) begin
      for (int c = 0; c < NB_COL; c++) begin
        if (en[p] && we[p][c])
          mem[addr[p]][c*COL_WIDTH +: COL_WIDTH] <=
            din[p][c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [W-1:0] rd;
    logic [W-1:0] merged;
    logic [W-1:0] s1_d;
    logic         s1_v;

    assign rd = mem[addr[p]];

    always_comb begin
      merged = rd;
      for (int c = 0; c < NB_COL; c++) begin
        if (we[p][c])
          merged[c*COL_WIDTH +: COL_WIDTH] =
            din[p][c*COL_WIDTH +: COL_WIDTH];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_d <= '0;
        s1_v <= 1'b0;
      end else if (!en[p]) begin
        s1_v <= 1'b0;
      end else if (we[p] == '0) begin
        s1_d <= rd;
        s1_v <= 1'b1;
      end else if (NO_CHANGE) begin
        s1_v <= 1'b0;
      end else if (RD_FIRST) begin
        s1_d <= rd;
        s1_v <= 1'b1;
      end else begin
        s1_d <= merged;
        s1_v <= 1'b1;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [W-1:0] s2_d;
      logic         s2_v;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s2_d <= '0;
          s2_v <= 1'b0;
        end else begin
          s2_v <= s1_v;
          if (s1_v) s2_d <= s1_d;
        end
      end

      assign dout[p] = s2_d;
      assign vout[p] = s2_v;
    end else begin : g_noreg
      assign dout[p] = s1_d;
      assign vout[p] = s1_v;
    end
  end

endmodule

// File: tb/tb_bram_2p_byte_en.sv
// Directed bench for bram_2p_byte_en: three instances cover
// WRITE_FIRST/lat1, READ_FIRST/lat2, NO_CHANGE/lat1.
module tb_bram_2p_byte_en;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [1:0]  a_we, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;

  logic [15:0] dout [3][2];
  logic        vout [3][2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bram_2p_byte_en #(
    .NB_COL(2), .COL_WIDTH(8), .RAM_ADDR_BITS(3),
    .READ_MODE("WRITE_FIRST"), .OUT_REG(0)
  ) dut_wf (
    .clk_i(clk), .rst_i(rst),
    .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_data),
    .a_data_o(dout[0][0]), .a_valid_o(vout[0][0]),
    .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_data_o(dout[0][1]), .b_valid_o(vout[0][1])
  );

  bram_2p_byte_en #(
    .NB_COL(2), .COL_WIDTH(8), .RAM_ADDR_BITS(3),
    .READ_MODE("READ_FIRST"), .OUT_REG(1)
  ) dut_rf (
    .clk_i(clk), .rst_i(rst),
    .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_data),
    .a_data_o(dout[1][0]), .a_valid_o(vout[1][0]),
    .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_data_o(dout[1][1]), .b_valid_o(vout[1][1])
  );

  bram_2p_byte_en #(
    .NB_COL(2), .COL_WIDTH(8), .RAM_ADDR_BITS(3),
    .READ_MODE("NO_CHANGE"), .OUT_REG(0)
  ) dut_nc (
    .clk_i(clk), .rst_i(rst),
    .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_data),
    .a_data_o(dout[2][0]), .a_valid_o(vout[2][0]),
    .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_data_o(dout[2][1]), .b_valid_o(vout[2][1])
  );

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(int p, logic en, logic [1:0] we,
                       logic [2:0] ad, logic [15:0] d);
    if (p == 0) begin
      a_en = en; a_we = we; a_addr = ad; a_data = d;
    end else begin
      b_en = en; b_we = we; b_addr = ad; b_data = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 2'b00, 3'd0, 16'h0);
    drive(1, 1'b0, 2'b00, 3'd0, 16'h0);
  endtask

  task automatic wr(int p, logic [2:0] ad, logic [15:0] d, logic [1:0] we);
    @(negedge clk); drive(p, 1'b1, we, ad, d);
    @(negedge clk); drive(p, 1'b0, 2'b00, 3'd0, 16'h0);
  endtask

  // read on one port; lat-1 instances checked after 1 edge, lat-2 after 2
  task automatic rd(string tag, int p, logic [2:0] ad, logic [15:0] exp);
    @(negedge clk); drive(p, 1'b1, 2'b00, ad, 16'h0);
    @(negedge clk); drive(p, 1'b0, 2'b00, 3'd0, 16'h0);
    chk({tag, "_wf_d"}, dout[0][p], exp);
    chk({tag, "_wf_v"}, 16'(vout[0][p]), 16'h1);
    chk({tag, "_nc_d"}, dout[2][p], exp);
    chk({tag, "_nc_v"}, 16'(vout[2][p]), 16'h1);
    chk({tag, "_rf_v_early"}, 16'(vout[1][p]), 16'h0);
    @(negedge clk);
    chk({tag, "_rf_d"}, dout[1][p], exp);
    chk({tag, "_rf_v"}, 16'(vout[1][p]), 16'h1);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_a_d%0d", k), dout[k][0], 16'h0);
      chk($sformatf("rst_b_v%0d", k), 16'(vout[k][1]), 16'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: fill through A, stream back through B
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0, 1'b1, 2'b11, 3'(i), 16'h1100 + 16'(i));
    end
    @(negedge clk); idle();
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 8) begin
        chk($sformatf("fill_wf_%0d", i-1), dout[0][1], 16'h1100 + 16'(i-1));
        chk($sformatf("fill_wf_v%0d", i-1), 16'(vout[0][1]), 16'h1);
        chk($sformatf("fill_nc_%0d", i-1), dout[2][1], 16'h1100 + 16'(i-1));
      end
      if (i == 9) chk("fill_wf_vend", 16'(vout[0][1]), 16'h0);
      if (i == 1) chk("fill_rf_lat", 16'(vout[1][1]), 16'h0);
      if (i >= 2) begin
        chk($sformatf("fill_rf_%0d", i-2), dout[1][1], 16'h1100 + 16'(i-2));
        chk($sformatf("fill_rf_v%0d", i-2), 16'(vout[1][1]), 16'h1);
      end
      if (i < 8) drive(1, 1'b1, 2'b00, 3'(i), 16'h0);
      else       drive(1, 1'b0, 2'b00, 3'd0, 16'h0);
    end

    // 2: byte enable
    wr(0, 3'd3, 16'hAABB, 2'b11);
    wr(0, 3'd3, 16'h1234, 2'b01);
    rd("be", 1, 3'd3, 16'hAA34);

    // 3: same-port read modes
    wr(0, 3'd5, 16'h00FF, 2'b11);
    rd("m_pre", 0, 3'd5, 16'h00FF);
    @(negedge clk); drive(0, 1'b1, 2'b11, 3'd5, 16'hC3C3);
    @(negedge clk); idle();
    chk("mode_wf_d", dout[0][0], 16'hC3C3);
    chk("mode_wf_v", 16'(vout[0][0]), 16'h1);
    chk("mode_nc_d", dout[2][0], 16'h00FF);
    chk("mode_nc_v", 16'(vout[2][0]), 16'h0);
    @(negedge clk);
    chk("mode_rf_d", dout[1][0], 16'h00FF);
    chk("mode_rf_v", 16'(vout[1][0]), 16'h1);
    rd("m_post", 1, 3'd5, 16'hC3C3);

    // 4: cross-port collisions
    wr(0, 3'd2, 16'h0000, 2'b11);
    @(negedge clk);
    drive(0, 1'b1, 2'b11, 3'd2, 16'h1111);
    drive(1, 1'b1, 2'b10, 3'd2, 16'h2222);
    @(negedge clk); idle();
    rd("ww", 0, 3'd2, 16'h1111);
    wr(0, 3'd4, 16'h5555, 2'b11);
    @(negedge clk);
    drive(0, 1'b1, 2'b11, 3'd4, 16'h6666);
    drive(1, 1'b1, 2'b00, 3'd4, 16'h0);
    @(negedge clk); idle();
    chk("rw_wf_d", dout[0][1], 16'h5555);
    chk("rw_nc_d", dout[2][1], 16'h5555);
    @(negedge clk);
    chk("rw_rf_d", dout[1][1], 16'h5555);
    rd("rw_post", 1, 3'd4, 16'h6666);

    // 5: enable low ignores write strobes
    wr(0, 3'd1, 16'h0101, 2'b11);
    @(negedge clk); drive(0, 1'b0, 2'b11, 3'd1, 16'hFFFF);
    @(negedge clk); idle();
    chk("enlo_wf_d", dout[0][0], 16'h0101);
    chk("enlo_wf_v", 16'(vout[0][0]), 16'h0);
    chk("enlo_nc_d", dout[2][0], 16'h1111);
    @(negedge clk);
    chk("enlo_rf_d", dout[1][0], 16'h1101);
    chk("enlo_rf_v", 16'(vout[1][0]), 16'h0);
    rd("enlo_mem", 1, 3'd1, 16'h0101);

    // 6: reset while a read is in flight
    wr(0, 3'd6, 16'hBEEF, 2'b11);
    @(negedge clk); drive(1, 1'b1, 2'b00, 3'd6, 16'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mrst_d%0d", k), dout[k][1], 16'h0);
      chk($sformatf("mrst_v%0d", k), 16'(vout[k][1]), 16'h0);
    end
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("mrst_hold_rf_v", 16'(vout[1][1]), 16'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("mrst_rel_wf_v", 16'(vout[0][1]), 16'h0);
    chk("mrst_rel_rf_v", 16'(vout[1][1]), 16'h0);
    rd("mrst_mem", 1, 3'd6, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_2p_byte_en.md
# bram_2p_byte_en

True dual-port block RAM with per-column byte-write enables, a selectable same-port read mode and an optional output register stage. It generalises the single-port byte-enable BRAM to two independent ports, A and B, on one clock. Each port has a registered read path and a `valid` flag that tracks read latency. The block is the shared-buffer building block for the lab designs that need concurrent producer/consumer access.

## Interface
- `NB_COL`, 4, number of byte columns per word.
- `COL_WIDTH`, 8, bits per column; word width W = NB_COL*COL_WIDTH.
- `RAM_ADDR_BITS`, 10, address width; depth = 2**RAM_ADDR_BITS.
- `READ_MODE`, "WRITE_FIRST", same-port read behaviour on a write cycle:
  - "WRITE_FIRST"
  - "READ_FIRST"
  - "NO_CHANGE"
- `OUT_REG`, 0, set to 1 to add a second output register (read latency 2 instead of 1).
- `clk_i  in  1`  single clock; all ports are sampled on its rising edge.
- `rst_i  in  1`  asynchronous, active-high reset.
- `a_en_i  in  1`  port A access enable.
- `a_we_i  in  NB_COL`  port A column write enables; only effective while `a_en_i`=1.
- `a_addr_i  in  RAM_ADDR_BITS`  port A word address.
- `a_data_i  in  W`  port A write data.
- `a_data_o  out  W`  port A read data.
- `a_valid_o  out  1`  port A read data valid.
- `b_*` port B: the same set of six signals with identical meaning.

## Operation
- The memory array is W x 2**RAM_ADDR_BITS. Every address is in range; there is no wrap logic.
- Access cycle: a port with `en_i`=1 on a rising edge performs one access.
  - It writes column c (bits c*COL_WIDTH +: COL_WIDTH) of `data_i` where `we_i[c]`=1.
  - Unselected columns keep their contents.
- `en_i`=0: no access. `we_i` and `data_i` are ignored, and `data_o` holds its value.
- Pure read (`en_i`=1, `we_i`=0): the stage-1 register loads mem[addr] and the stage-1 valid flag is set.
- Same-port write (`en_i`=1, `we_i`≠0), by READ_MODE:
  - WRITE_FIRST: stage 1 loads the merged word (written columns new, other columns old); valid is set.
  - READ_FIRST: stage 1 loads the pre-write word; valid is set.
  - NO_CHANGE: stage 1 holds its value; valid is cleared.
- Cross-port collisions on the same address in the same cycle:
  - Read on one port, write on the other: the reader gets the pre-write word.
  - Both ports write: each column with only one enable takes that port's data. A column enabled on both ports takes port A's data (A has priority).
  - Both ports read: both get the same word.
- Output pipeline:
  - OUT_REG=0: `data_o`/`valid_o` are driven directly from stage 1.
  - OUT_REG=1: stage 2 copies stage 1 on every clock. `data_o` of stage 2 updates only when stage-1 valid is 1; `valid_o` of stage 2 always follows stage-1 valid.
- Reset (asynchronous assert, synchronous release):
  - Clears every stage register and valid flag, so `a/b_data_o`=0 and `a/b_valid_o`=0 immediately.
  - Does not clear the memory array; contents after reset are unchanged.
- Reset mid-operation:
  - Any read in flight is discarded with no valid pulse.
  - A write sampled on the same edge that reset is asserted is not guaranteed.
  - The first edge after release is a normal access cycle.

## Timing
- Read latency from the edge sampling `en_i`=1 to `data_o`/`valid_o`:
  - OUT_REG=0: 1 edge, visible in the following cycle.
  - OUT_REG=1: 2 edges.
- `valid_o` is high for exactly one cycle per accepted read, unless the next cycle is also a read.
- Back-to-back reads on consecutive cycles give a continuous `valid_o` with one word per cycle; throughput is 1 access/port/cycle.
- A write followed by a read of the same address on the next cycle returns the new data, on either port.
- Combinational paths: none from inputs to outputs.

## Test plan
Configuration: NB_COL=2, COL_WIDTH=8, RAM_ADDR_BITS=3.
1. Fill and read back: write 0x1100+i to addresses 0..7 via port A, then read 0..7 back-to-back via port B. Required: B returns 0x1100..0x1107 in order, `b_valid_o` is high for 8 consecutive cycles, and the first word appears after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
2. Byte enable: mem[3]=0xAABB; A writes 0x1234 with `we`=2'b01. Required: a read returns 0xAA34.
3. Read modes: mem[5]=0x00FF; A writes 0xC3C3 with `we`=2'b11 and `en`=1. Required:
   - WRITE_FIRST: `a_data_o`=0xC3C3, `a_valid_o`=1.
   - READ_FIRST: `a_data_o`=0x00FF, `a_valid_o`=1.
   - NO_CHANGE: `a_data_o` keeps its previous value, `a_valid_o`=0.
   - In all modes a later read returns 0xC3C3.
4. Cross-port collision: mem[2]=0x0000. Same cycle: A writes 0x1111 with `we`=2'b11, B writes 0x2222 with `we`=2'b10. Required: mem[2]=0x1111 (A wins the upper column). Then, with mem[4]=0x5555, B reads address 4 while A writes 0x6666 there. Required: `b_data_o`=0x5555, and the next read returns 0x6666.
5. Enable low: `en_i`=0 with `we_i`=2'b11 and data 0xFFFF at address 1, which holds 0x0101. Required: mem[1]=0x0101, and `data_o`/`valid_o` are unchanged.
6. Reset mid-read: issue a read of address 6 (mem[6]=0xBEEF) on B and assert `rst_i` before the output edge. Required: `b_data_o`=0 and `b_valid_o`=0 immediately with no valid pulse. After release, reading address 6 returns 0xBEEF.
